// File: rtl/mvma_pkg.sv
// Shared constants, types and state encoding for the matrix-vector MAC driver.
package mvma_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned RES_W  = 16;

  // Frame layout: K*K matrix bytes, then K bias bytes, then K vector bytes.
  function automatic int unsigned frame_len(input int unsigned k);
    return k * k + 2 * k;
  endfunction

  localparam int unsigned MVMA_K  = 4;
  localparam int unsigned MVMA_FL = frame_len(MVMA_K);

  typedef logic signed [BYTE_W-1:0] mvma_byte_t;
  typedef logic signed [RES_W-1:0]  mvma_res_t;

  typedef logic [1:0] mvma_state_t;
  localparam mvma_state_t ST_IDLE = 2'd0;
  localparam mvma_state_t ST_SEND = 2'd1;
  localparam mvma_state_t ST_RECV = 2'd2;
  localparam mvma_state_t ST_DONE = 2'd3;

endpackage : mvma_pkg

// File: rtl/mvma_frame_buf.sv
// Frame register file: one synchronous write port, one asynchronous read port.
// Not reset; contents are only meaningful once the host has written them.
module mvma_frame_buf
  import mvma_pkg::*;
#(
  parameter int unsigned DEPTH = MVMA_FL,
  parameter int unsigned AW    = $clog2(MVMA_FL)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [BYTE_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [BYTE_W-1:0] rd_data_c
);

  mvma_byte_t mem [DEPTH];

  // Host write; addresses beyond the frame are dropped.
  always_ff @(posedge clk) begin
    if (wr_en && (32'(wr_addr) < DEPTH)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data_c = mem[rd_addr];

endmodule : mvma_frame_buf

// File: rtl/mvma_driver.sv
// Streams a buffered matrix/bias/vector frame to the MAC engine and captures
// the K results it returns into a readable result buffer.
module mvma_driver
  import mvma_pkg::*;
#(
  parameter int unsigned K = MVMA_K
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                cfg_wr_en,
  input  logic [$clog2(frame_len(K))-1:0]     cfg_addr,
  input  logic [BYTE_W-1:0]                   cfg_data,
  input  logic                                start,
  output logic                                busy,
  output logic                                done,
  output logic                                tx_valid,
  input  logic                                tx_ready,
  output logic [BYTE_W-1:0]                   tx_data,
  input  logic                                rx_valid,
  output logic                                rx_ready,
  input  logic [RES_W-1:0]                    rx_data,
  input  logic                                rx_overflow,
  input  logic [$clog2(K)-1:0]                res_addr,
  output logic [RES_W-1:0]                    res_data,
  output logic                                res_ovf
);

  localparam int unsigned FL     = frame_len(K);
  localparam int unsigned SEND_W = $clog2(FL);
  localparam int unsigned RX_W   = $clog2(K);

  mvma_state_t       state_q, state_d;
  logic [SEND_W-1:0] send_cnt_q, send_cnt_d;
  logic [RX_W-1:0]   rx_cnt_q, rx_cnt_d;
  logic              busy_d, done_d, tx_valid_d, rx_ready_d;
  logic              cfg_we;
  logic              capture;
  logic              tx_last;
  logic              rx_last;

  mvma_res_t         res_q [K];
  logic [K-1:0]      ovf_q;

  assign tx_last = (send_cnt_q == SEND_W'(FL - 1));
  assign rx_last = (rx_cnt_q == RX_W'(K - 1));

  mvma_frame_buf #(
    .DEPTH (FL),
    .AW    (SEND_W)
  ) u_frame_buf (
    .clk       (clk),
    .wr_en     (cfg_we),
    .wr_addr   (cfg_addr),
    .wr_data   (cfg_data),
    .rd_addr   (send_cnt_q),
    .rd_data_c (tx_data)
  );

  // Next-state, counter and registered-output decode.
  always_comb begin
    state_d    = state_q;
    send_cnt_d = send_cnt_q;
    rx_cnt_d   = rx_cnt_q;
    cfg_we     = 1'b0;
    capture    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cfg_we = cfg_wr_en;
        if (start) begin
          state_d    = ST_SEND;
          send_cnt_d = '0;
        end
      end
      ST_SEND: begin
        if (tx_valid && tx_ready) begin
          if (tx_last) begin
            state_d    = ST_RECV;
            send_cnt_d = '0;
            rx_cnt_d   = '0;
          end else begin
            send_cnt_d = send_cnt_q + SEND_W'(1);
          end
        end
      end
      ST_RECV: begin
        if (rx_valid && rx_ready) begin
          capture = 1'b1;
          if (rx_last) begin
            state_d  = ST_DONE;
            rx_cnt_d = '0;
          end else begin
            rx_cnt_d = rx_cnt_q + RX_W'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d     = (state_d != ST_IDLE);
    tx_valid_d = (state_d == ST_SEND);
    rx_ready_d = (state_d == ST_RECV);
    done_d     = (state_d == ST_DONE);
  end

  // State, counters and handshake/status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      send_cnt_q <= '0;
      rx_cnt_q   <= '0;
      busy       <= 1'b0;
      tx_valid   <= 1'b0;
      rx_ready   <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      send_cnt_q <= send_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      busy       <= busy_d;
      tx_valid   <= tx_valid_d;
      rx_ready   <= rx_ready_d;
      done       <= done_d;
    end
  end

  // Result capture; values persist until overwritten or reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(K); i++) begin
        res_q[i] <= '0;
      end
      ovf_q <= '0;
    end else if (capture) begin
      res_q[rx_cnt_q] <= rx_data;
      ovf_q[rx_cnt_q] <= rx_overflow;
    end
  end

  assign res_data = res_q[res_addr];
  assign res_ovf  = ovf_q[res_addr];

endmodule : mvma_driver

// File: tb/tb_mvma_driver.sv
// Scoreboard bench for mvma_driver with a behavioural MAC engine model.
module tb_mvma_driver;

  localparam int K  = 4;
  localparam int FL = K * K + 2 * K;

  typedef logic [7:0]  frame_t   [FL];
  typedef logic [15:0] res_arr_t [K];
  typedef bit          ovf_arr_t [K];

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_wr_en = 1'b0;
  logic [4:0]  cfg_addr = '0;
  logic [7:0]  cfg_data = '0;
  logic        start = 1'b0;
  logic        busy, done, tx_valid, rx_ready, res_ovf;
  logic        tx_ready = 1'b0;
  logic [7:0]  tx_data;
  logic        rx_valid = 1'b0;
  logic [15:0] rx_data = '0;
  logic        rx_overflow = 1'b0;
  logic [1:0]  res_addr = '0;
  logic [15:0] res_data;

  mvma_driver #(.K(K)) dut (
    .clk         (clk),
    .reset       (reset),
    .cfg_wr_en   (cfg_wr_en),
    .cfg_addr    (cfg_addr),
    .cfg_data    (cfg_data),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .rx_data     (rx_data),
    .rx_overflow (rx_overflow),
    .res_addr    (res_addr),
    .res_data    (res_data),
    .res_ovf     (res_ovf)
  );

  initial forever #5 clk = ~clk;

  int          n_vec = 0;
  int          n_err = 0;
  int          tx_total = 0;
  int          base = 0;
  logic [7:0]  sb_q [$];
  frame_t      shadow;
  bit          rdy_rand = 1'b0;
  bit          inject = 1'b0;

  frame_t      e_bytes;
  int          e_nb = 0;
  int          e_nr = 0;
  int          e_taken = 0;
  res_arr_t    e_res;
  ovf_arr_t    e_ovf;
  bit          res_pres = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // y[i] = b[i] + sum_j M[i][j]*x[j] on signed bytes; overflow if outside 16-bit signed.
  function automatic void mac_ref(input frame_t f, output res_arr_t r, output ovf_arr_t o);
    for (int i = 0; i < K; i++) begin
      int acc;
      acc = int'($signed(f[K*K+i]));
      for (int j = 0; j < K; j++) begin
        acc += int'($signed(f[i*K+j])) * int'($signed(f[K*K+K+j]));
      end
      r[i] = 16'(acc);
      o[i] = (acc > 32767) || (acc < -32768);
    end
  endfunction

  // Engine model: absorbs a frame, then returns K results with its own pacing.
  initial begin : engine
    bit         t_hs;
    bit         r_hs;
    logic [7:0] tdat;
    forever begin
      @(negedge clk);
      t_hs = tx_valid && tx_ready;
      r_hs = rx_valid && rx_ready;
      tdat = tx_data;
      @(posedge clk);
      #1;
      if (!reset) begin
        e_nb = 0; e_nr = 0; e_taken = 0; res_pres = 1'b0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_overflow = 1'b0; rx_data = '0;
      end else begin
        if (t_hs && e_nb < FL) begin
          if (e_nb == 0) e_taken = 0;
          e_bytes[e_nb] = tdat;
          e_nb++;
          if (e_nb == FL) mac_ref(e_bytes, e_res, e_ovf);
        end
        if (r_hs && res_pres) begin
          e_nr++;
          e_taken++;
          res_pres = 1'b0;
          if (e_nr == K) begin
            e_nb = 0;
            e_nr = 0;
          end
        end
        tx_ready = (e_nb < FL) && (!rdy_rand || $urandom_range(0, 1) == 1);
        if (e_nb == FL) begin
          if (!res_pres) begin
            if (!rdy_rand || $urandom_range(0, 1) == 1) begin
              rx_valid = 1'b1; rx_data = e_res[e_nr]; rx_overflow = e_ovf[e_nr]; res_pres = 1'b1;
            end else begin
              rx_valid = 1'b0;
            end
          end
        end else begin
          rx_valid = inject; rx_data = 16'hDEAD; rx_overflow = inject;
        end
      end
    end
  end

  // Monitor: byte scoreboard, stall stability, rx gating and done pulse checks.
  initial begin : monitor
    bit         stall_pend = 1'b0;
    logic [7:0] stall_dat = '0;
    bit         prev_done = 1'b0;
    logic [7:0] exp_b;
    forever begin
      @(negedge clk);
      if (!reset) begin
        stall_pend = 1'b0;
        prev_done  = 1'b0;
      end else begin
        if (stall_pend) begin
          chk("tx_valid held", 32'(tx_valid), 32'd1);
          chk("tx_data held", 32'(tx_data), 32'(stall_dat));
        end
        if (tx_valid && tx_ready) begin
          tx_total++;
          if (sb_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected byte: got %0h expected none at %0t", tx_data, $time);
          end else begin
            exp_b = sb_q.pop_front();
            chk("tx byte", 32'(tx_data), 32'(exp_b));
          end
        end
        stall_pend = tx_valid && !tx_ready;
        stall_dat  = tx_data;
        if (rx_valid && (tx_valid || !busy)) chk("rx_ready outside RECV", 32'(rx_ready), 32'd0);
        if (done) begin
          chk("done one cycle", 32'(prev_done), 32'd0);
          chk("results before done", 32'(e_taken), 32'(K));
        end
        prev_done = done;
      end
    end
  end

  task automatic load_frame(input frame_t f);
    for (int a = 0; a < FL; a++) begin
      @(posedge clk);
      #1;
      cfg_wr_en = 1'b1;
      cfg_addr  = 5'(a);
      cfg_data  = f[a];
      shadow[a] = f[a];
    end
    @(posedge clk);
    #1;
    cfg_wr_en = 1'b0;
  endtask

  task automatic start_frame();
    @(posedge clk);
    #1;
    for (int a = 0; a < FL; a++) sb_q.push_back(shadow[a]);
    base  = tx_total;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic check_frame(input string tag);
    res_arr_t er;
    ovf_arr_t eo;
    bit       ok = 1'b0;
    mac_ref(shadow, er, eo);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk({tag, " done timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, " busy in done"}, 32'(busy), 32'd1);
      for (int i = 0; i < K; i++) begin
        res_addr = 2'(i);
        #1;
        chk({tag, " res_data"}, 32'(res_data), 32'(er[i]));
        chk({tag, " res_ovf"}, 32'(res_ovf), 32'(eo[i]));
      end
      chk({tag, " bytes left"}, 32'(sb_q.size()), 32'd0);
      chk({tag, " byte count"}, 32'(tx_total - base), 32'(FL));
      @(posedge clk);
      #1;
      chk({tag, " done after"}, 32'(done), 32'd0);
      chk({tag, " busy after"}, 32'(busy), 32'd0);
    end
  endtask

  task automatic wait_bytes(input int n);
    for (int c = 0; c < 500; c++) begin
      @(posedge clk);
      if (tx_total - base >= n) break;
    end
  endtask

  initial begin : main
    frame_t f;
    repeat (3) @(posedge clk);
    #2;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset tx_valid", 32'(tx_valid), 32'd0);
    chk("reset rx_ready", 32'(rx_ready), 32'd0);
    for (int i = 0; i < K; i++) begin
      res_addr = 2'(i);
      #1;
      chk("reset res_data", 32'(res_data), 32'd0);
      chk("reset res_ovf", 32'(res_ovf), 32'd0);
    end
    reset = 1'b1;

    // Identity matrix, zero bias, x = 1..4
    for (int a = 0; a < FL; a++) f[a] = 8'h00;
    for (int i = 0; i < K; i++) f[i*K+i] = 8'h01;
    for (int j = 0; j < K; j++) f[K*K+K+j] = 8'(j + 1);
    load_frame(f);
    start_frame();
    check_frame("identity");

    // Same frame without reload, randomly stalled handshakes
    rdy_rand = 1'b1;
    start_frame();
    check_frame("stalled");

    // Saturating products flag overflow on every result
    rdy_rand = 1'b0;
    for (int a = 0; a < FL; a++) f[a] = 8'd127;
    for (int i = 0; i < K; i++) f[K*K+i] = 8'h00;
    load_frame(f);
    start_frame();
    check_frame("overflow");

    // Host write and start during SEND must be ignored
    for (int a = 0; a < FL; a++) f[a] = 8'($urandom);
    f[0] = 8'h12;
    load_frame(f);
    start_frame();
    wait_bytes(3);
    #1;
    start = 1'b1; cfg_wr_en = 1'b1; cfg_addr = 5'd0; cfg_data = 8'h55;
    @(posedge clk);
    #1;
    start = 1'b0; cfg_wr_en = 1'b0;
    check_frame("ignored cfg");
    start_frame();
    check_frame("reuse");

    // rx_valid asserted early must not be captured before RECV
    inject   = 1'b1;
    rdy_rand = 1'b1;
    start_frame();
    check_frame("early rx");
    inject   = 1'b0;

    // Reset after 10 bytes aborts the frame; next start resends from byte 0
    rdy_rand = 1'b0;
    start_frame();
    wait_bytes(10);
    #2;
    reset = 1'b0;
    #1;
    chk("abort byte count", 32'(tx_total - base), 32'd10);
    chk("abort tx_valid", 32'(tx_valid), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort rx_ready", 32'(rx_ready), 32'd0);
    chk("abort done", 32'(done), 32'd0);
    for (int i = 0; i < K; i++) begin
      res_addr = 2'(i);
      #1;
      chk("abort res_data", 32'(res_data), 32'd0);
      chk("abort res_ovf", 32'(res_ovf), 32'd0);
    end
    sb_q.delete();
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b1;
    start_frame();
    check_frame("after abort");

    // Random frames with random pacing
    rdy_rand = 1'b1;
    repeat (3) begin
      for (int a = 0; a < FL; a++) f[a] = 8'($urandom);
      load_frame(f);
      start_frame();
      check_frame("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_mvma_driver

// File: doc/mvma_driver.md
MVMA_DRIVER -- requirements
Module: mvma_driver

Interface
REQ-001 Parameter: K, default 4, matrix dimension; frame length FL = K*K + 2*K (24 at default).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (asserted when 0).
REQ-004 cfg_wr_en  input  1  host write strobe into frame buffer.
REQ-005 cfg_addr  input  5  frame buffer address: 0..K*K-1 matrix row-major, K*K..K*K+K-1 bias b, K*K+K..FL-1 vector x.
REQ-006 cfg_data  input  8  signed frame element.
REQ-007 start  input  1  one-cycle request to transmit the buffered frame.
REQ-008 busy  output  1  high in any state other than IDLE.
REQ-009 done  output  1  one-cycle pulse when all K results are captured.
REQ-010 tx_valid / tx_ready / tx_data  output / input / output  1 / 1 / 8  byte stream to the multiply-accumulate engine's s_valid/s_ready/data_in.
REQ-011 rx_valid / rx_ready / rx_data / rx_overflow  input / output / input / input  1 / 1 / 16 / 1  result stream from the engine's m_valid/m_ready/data_out/overflow.
REQ-012 res_addr  input  2  result buffer read index 0..K-1.
REQ-013 res_data / res_ovf  output  16 / 1  combinational read of result entry res_addr and its overflow flag.

Function
REQ-014 FSM states IDLE, SEND, RECV, DONE; reset state IDLE.
REQ-015 IDLE: cfg_wr_en writes cfg_data into buffer[cfg_addr]; addresses >= FL ignored; start -> SEND with send_cnt = 0.
REQ-016 cfg_wr_en and start outside IDLE are ignored; buffer contents unchanged.
REQ-017 SEND: tx_valid = 1, tx_data = buffer[send_cnt]; byte transfers on the cycle tx_valid && tx_ready; send_cnt increments only on transfer.
REQ-018 tx_data stable while tx_valid = 1 and tx_ready = 0; tx_valid never drops mid-frame.
REQ-019 Transfer order: M[0][0]..M[K-1][K-1], then b[0..K-1], then x[0..K-1].
REQ-020 Transfer of byte FL-1 -> RECV next cycle with rx_cnt = 0; tx_valid = 0 that cycle onward.
REQ-021 RECV: rx_ready = 1; on rx_valid && rx_ready, res[rx_cnt] <= rx_data, ovf[rx_cnt] <= rx_overflow, rx_cnt increments.
REQ-022 rx_ready = 0 in IDLE, SEND, DONE; rx_valid outside RECV is held off, never captured.
REQ-023 Capture of result K-1 -> DONE; DONE asserts done for exactly one cycle, then -> IDLE.
REQ-024 start in the DONE cycle is ignored; a new start is accepted in IDLE the following cycle.
REQ-025 Result buffer retains values until next capture to the same index or reset; the frame buffer is reusable without reload.
REQ-026 No arithmetic on data; rx_data stored unmodified, full 16-bit signed width.

Reset
REQ-027 Reset low, asynchronously: state IDLE, send_cnt = rx_cnt = 0, tx_valid = 0, rx_ready = 0, busy = 0, done = 0, all res and ovf entries = 0.
REQ-028 Frame buffer is not cleared by reset; contents are undefined until written.
REQ-029 Reset mid-SEND or mid-RECV aborts the frame immediately; no partial results are flagged as done.

Structure
REQ-030 Shared package mvma_pkg holds K, FL, the state enum type, and the byte (8-bit signed) and result (16-bit signed) typedefs.
REQ-031 One sub-module, mvma_frame_buf: FL x 8 register file, single write port, asynchronous read port (tx_data path).
REQ-032 Counters sized to clog2(FL) and clog2(K), with no wrap beyond terminal count.

Verification
REQ-033 Identity M, b = 0, x = {1,2,3,4}, tx_ready = 1, engine model returns products -> 24 bytes in order, done after 4th result, res = {1,2,3,4}, ovf = 0.
REQ-034 Same frame, tx_ready random 50% -> identical byte sequence, no duplicates or drops, tx_data stable while stalled.
REQ-035 M all 127, x all 127, b = 0, model asserts rx_overflow = 1 with results -> res_ovf = 1 for all four indices.
REQ-036 reset low after 10 bytes transferred -> tx_valid = 0 same cycle, busy = 0, res all 0; a new start resends from byte 0.
REQ-037 start and cfg_wr_en (addr 0, data 0x55) during SEND -> ignored; byte 0 of the next frame unchanged.
REQ-038 rx_valid = 1 during SEND -> rx_ready = 0, no capture; capture begins only in RECV.
